// File: rtl/stream_demux.sv
// Registered 1:NUM_OUT stream demultiplexer with a single holding register.
// Beats addressed past the last port are consumed, dropped and counted.
module stream_demux #(
   parameter int DATA_W  = 8,
   parameter int NUM_OUT = 2,   // must satisfy 2 <= NUM_OUT <= 2**SEL_W
   parameter int SEL_W   = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [SEL_W-1:0]   in_sel,
   output logic [NUM_OUT-1:0] out_valid,
   input  logic [NUM_OUT-1:0] out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [SEL_W-1:0]   out_sel,
   output logic               bad_sel,
   output logic [7:0]         drop_cnt
);

   localparam logic [SEL_W:0] NUM_OUT_W = (SEL_W+1)'(NUM_OUT);

   logic              r_hold_v;
   logic [DATA_W-1:0] r_hold_data;
   logic [SEL_W-1:0]  r_hold_sel;
   logic              r_bad_sel;
   logic [7:0]        r_drop_cnt;

   logic w_sel_ready;
   logic w_drain;
   logic w_accept;
   logic w_good;

   // Only the ready of the port currently being driven matters; others are ignored.
   always_comb begin
      w_sel_ready = 1'b0;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (r_hold_sel == SEL_W'(i)) begin
            w_sel_ready = out_ready[i];
         end
      end
   end

   assign w_drain  = r_hold_v && w_sel_ready;
   assign in_ready = !r_hold_v || w_drain;
   assign w_accept = in_valid && in_ready;
   assign w_good   = ({1'b0, in_sel} < NUM_OUT_W);

   // A good accept overwrites the draining beat, giving full throughput without a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold_v    <= 1'b0;
         r_hold_data <= '0;
         r_hold_sel  <= '0;
         r_bad_sel   <= 1'b0;
         r_drop_cnt  <= 8'd0;
      end else begin
         r_bad_sel <= w_accept && !w_good;
         if (w_accept && !w_good && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
         if (w_accept && w_good) begin
            r_hold_v    <= 1'b1;
            r_hold_data <= in_data;
            r_hold_sel  <= in_sel;
         end else if (w_drain) begin
            r_hold_v <= 1'b0;
         end
      end
   end

   for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_valid
      assign out_valid[gi] = r_hold_v && (r_hold_sel == SEL_W'(gi));
   end

   assign out_data = r_hold_data;
   assign out_sel  = r_hold_sel;
   assign bad_sel  = r_bad_sel;
   assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 2-port instance (a_*) and a 3-port
// instance with 2-bit select (b_*) that exercises the drop path.
module tb_stream_demux;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_reset = 1'b1;
   logic       a_in_valid = 1'b0;
   logic       a_in_ready;
   logic [7:0] a_in_data = 8'h00;
   logic [0:0] a_in_sel = 1'b0;
   logic [1:0] a_out_valid;
   logic [1:0] a_out_ready = 2'b00;
   logic [7:0] a_out_data;
   logic [0:0] a_out_sel;
   logic       a_bad_sel;
   logic [7:0] a_drop_cnt;

   logic       b_reset = 1'b1;
   logic       b_in_valid = 1'b0;
   logic       b_in_ready;
   logic [7:0] b_in_data = 8'h00;
   logic [1:0] b_in_sel = 2'b00;
   logic [2:0] b_out_valid;
   logic [2:0] b_out_ready = 3'b000;
   logic [7:0] b_out_data;
   logic [1:0] b_out_sel;
   logic       b_bad_sel;
   logic [7:0] b_drop_cnt;

   int errors = 0;
   int checks = 0;

   stream_demux #(.DATA_W(8), .NUM_OUT(2), .SEL_W(1)) u_dut_a (
      .clk(clk), .reset(a_reset),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_sel(a_in_sel),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_sel(a_out_sel), .bad_sel(a_bad_sel), .drop_cnt(a_drop_cnt)
   );

   stream_demux #(.DATA_W(8), .NUM_OUT(3), .SEL_W(2)) u_dut_b (
      .clk(clk), .reset(b_reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_sel(b_in_sel),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_sel(b_out_sel), .bad_sel(b_bad_sel), .drop_cnt(b_drop_cnt)
   );

   // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      a_reset = 1'b1; b_reset = 1'b1;
      tick();
      tick();
      a_reset = 1'b0; b_reset = 1'b0;
      #1;
      checks++; if (a_out_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_a_valid: got %b expected 00", a_out_valid); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_a_ready: got %b expected 1", a_in_ready); end
      checks++; if (a_out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_a_data: got %h expected 00", a_out_data); end
      checks++; if (a_out_sel !== 1'b0) begin errors++; $display("[TB] FAIL reset_a_sel: got %b expected 0", a_out_sel); end
      checks++; if (a_bad_sel !== 1'b0) begin errors++; $display("[TB] FAIL reset_a_bad: got %b expected 0", a_bad_sel); end
      checks++; if (a_drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_a_drop: got %0d expected 0", a_drop_cnt); end
      checks++; if (b_out_valid !== 3'b000) begin errors++; $display("[TB] FAIL reset_b_valid: got %b expected 000", b_out_valid); end
      checks++; if (b_drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_b_drop: got %0d expected 0", b_drop_cnt); end
   endtask

   task automatic test_single();
      a_out_ready = 2'b11;
      a_in_valid = 1'b1; a_in_sel = 1'b1; a_in_data = 8'hA5;
      tick();
      a_in_valid = 1'b0;
      #1;
      checks++; if (a_out_valid !== 2'b10) begin errors++; $display("[TB] FAIL single_valid: got %b expected 10", a_out_valid); end
      checks++; if (a_out_data !== 8'hA5) begin errors++; $display("[TB] FAIL single_data: got %h expected a5", a_out_data); end
      checks++; if (a_out_sel !== 1'b1) begin errors++; $display("[TB] FAIL single_sel: got %b expected 1", a_out_sel); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %b expected 1", a_in_ready); end
      tick();
      checks++; if (a_out_valid !== 2'b00) begin errors++; $display("[TB] FAIL single_drained: got %b expected 00", a_out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] expValid;
      a_out_ready = 2'b11;
      for (int k = 0; k < 4; k++) begin
         a_in_valid = 1'b1; a_in_data = 8'(k + 1); a_in_sel = 1'(k % 2);
         #1;
         checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected 1", k, a_in_ready); end
         tick();
         expValid = (k % 2 == 1) ? 2'b10 : 2'b01;
         checks++; if (a_out_valid !== expValid) begin errors++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected %b", k, a_out_valid, expValid); end
         checks++; if (a_out_data !== 8'(k + 1)) begin errors++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", k, a_out_data, 8'(k + 1)); end
      end
      a_in_valid = 1'b0;
      tick();
      checks++; if (a_out_valid !== 2'b00) begin errors++; $display("[TB] FAIL b2b_idle: got %b expected 00", a_out_valid); end
   endtask

   task automatic test_stall();
      // Port 1 ready is held high throughout to show it is ignored while port 0 stalls.
      a_out_ready = 2'b10;
      a_in_valid = 1'b1; a_in_sel = 1'b0; a_in_data = 8'h3C;
      tick();
      a_in_sel = 1'b1; a_in_data = 8'h55;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready[%0d]: got %b expected 0", k, a_in_ready); end
         checks++; if (a_out_data !== 8'h3C) begin errors++; $display("[TB] FAIL stall_data[%0d]: got %h expected 3c", k, a_out_data); end
         checks++; if (a_out_valid !== 2'b01) begin errors++; $display("[TB] FAIL stall_valid[%0d]: got %b expected 01", k, a_out_valid); end
         tick();
      end
      a_out_ready = 2'b11;
      #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_ready: got %b expected 1", a_in_ready); end
      tick();
      a_in_valid = 1'b0;
      #1;
      checks++; if (a_out_valid !== 2'b10) begin errors++; $display("[TB] FAIL stall_next_valid: got %b expected 10", a_out_valid); end
      checks++; if (a_out_data !== 8'h55) begin errors++; $display("[TB] FAIL stall_next_data: got %h expected 55", a_out_data); end
      tick();
      checks++; if (a_out_valid !== 2'b00) begin errors++; $display("[TB] FAIL stall_idle: got %b expected 00", a_out_valid); end
   endtask

   task automatic test_bad_sel();
      int pulses = 0;
      int everValid = 0;
      b_out_ready = 3'b111;
      b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'hEE;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (b_bad_sel === 1'b1) pulses++;
         if (b_out_valid !== 3'b000) everValid++;
      end
      b_in_valid = 1'b0;
      tick();
      if (b_bad_sel === 1'b1) pulses++;
      checks++; if (pulses !== 10) begin errors++; $display("[TB] FAIL bad_pulses: got %0d expected 10", pulses); end
      checks++; if (everValid !== 0) begin errors++; $display("[TB] FAIL bad_no_valid: got %0d valid cycles expected 0", everValid); end
      checks++; if (b_drop_cnt !== 8'd10) begin errors++; $display("[TB] FAIL bad_count: got %0d expected 10", b_drop_cnt); end
      checks++; if (b_bad_sel !== 1'b0) begin errors++; $display("[TB] FAIL bad_pulse_end: got %b expected 0", b_bad_sel); end
      // Good beat to port 2, then a bad beat that arrives while it drains.
      b_in_valid = 1'b1; b_in_sel = 2'd2; b_in_data = 8'h77;
      tick();
      b_in_sel = 2'd3;
      #1;
      checks++; if (b_out_valid !== 3'b100) begin errors++; $display("[TB] FAIL good_port2_valid: got %b expected 100", b_out_valid); end
      checks++; if (b_out_data !== 8'h77) begin errors++; $display("[TB] FAIL good_port2_data: got %h expected 77", b_out_data); end
      checks++; if (b_bad_sel !== 1'b0) begin errors++; $display("[TB] FAIL good_no_bad: got %b expected 0", b_bad_sel); end
      tick();
      b_in_valid = 1'b0;
      #1;
      checks++; if (b_out_valid !== 3'b000) begin errors++; $display("[TB] FAIL drain_bad_valid: got %b expected 000", b_out_valid); end
      checks++; if (b_bad_sel !== 1'b1) begin errors++; $display("[TB] FAIL drain_bad_pulse: got %b expected 1", b_bad_sel); end
      checks++; if (b_drop_cnt !== 8'd11) begin errors++; $display("[TB] FAIL drain_bad_count: got %0d expected 11", b_drop_cnt); end
      tick();
   endtask

   task automatic test_saturate();
      b_reset = 1'b1;
      tick();
      b_reset = 1'b0;
      b_out_ready = 3'b111;
      b_in_valid = 1'b1; b_in_sel = 2'd3;
      for (int k = 0; k < 254; k++) tick();
      #1;
      checks++; if (b_drop_cnt !== 8'd254) begin errors++; $display("[TB] FAIL sat_254: got %0d expected 254", b_drop_cnt); end
      tick();
      checks++; if (b_drop_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_255: got %0d expected 255", b_drop_cnt); end
      for (int k = 0; k < 45; k++) tick();
      b_in_valid = 1'b0;
      #1;
      checks++; if (b_drop_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_hold: got %0d expected 255", b_drop_cnt); end
      checks++; if (b_bad_sel !== 1'b1) begin errors++; $display("[TB] FAIL sat_pulse: got %b expected 1", b_bad_sel); end
      tick();
   endtask

   task automatic test_reset_stall();
      b_out_ready = 3'b000;
      b_in_valid = 1'b1; b_in_sel = 2'd1; b_in_data = 8'h99;
      tick();
      b_in_valid = 1'b0;
      #1;
      checks++; if (b_out_valid !== 3'b010) begin errors++; $display("[TB] FAIL rst_stall_held: got %b expected 010", b_out_valid); end
      b_reset = 1'b1;
      tick();
      b_reset = 1'b0;
      #1;
      checks++; if (b_out_valid !== 3'b000) begin errors++; $display("[TB] FAIL rst_stall_valid: got %b expected 000", b_out_valid); end
      checks++; if (b_drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rst_stall_drop: got %0d expected 0", b_drop_cnt); end
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_stall_ready: got %b expected 1", b_in_ready); end
      b_out_ready = 3'b111;
      tick();
      checks++; if (b_out_valid !== 3'b000) begin errors++; $display("[TB] FAIL rst_stall_ghost: got %b expected 000", b_out_valid); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_bad_sel();
      test_saturate();
      test_reset_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
